// File: rtl/rv32_x_pkg.sv
// Shared types for the DCCM posted-store buffer.
// Holds the store-type encodings, the byte-enable generator and the buffer entry layout.
package rv32_x_pkg;

  localparam logic [1:0] ST_BYTE = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_WORD = 2'b10;

  // addr is wide enough for any AW; the buffer only uses its low AW bits
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  // An all-zero result marks a store that must be dropped
  function automatic logic [3:0] be_gen(input logic [1:0] st_type, input logic [1:0] off);
    logic [3:0] be;
    be = 4'h0;
    case (st_type)
      ST_BYTE: be = 4'b0001 << off;
      ST_HALF: if (!off[0]) be = 4'b0011 << off;
      ST_WORD: if (off == 2'b00) be = 4'hF;
      default: be = 4'h0;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/stb_byte_merge.sv
// Age-ordered byte merge of buffered store entries over a base word (store-to-load forwarding).
// Entry 0 is oldest; a younger entry overwrites any byte an older one wrote.
module stb_byte_merge #(
  parameter int DEPTH = 4
) (
  input  logic [31:0]         base_i,
  input  logic [DEPTH*32-1:0] data_i,
  input  logic [DEPTH*4-1:0]  be_i,
  output logic [31:0]         merged_o
);

  always_comb begin
    merged_o = base_i;
    for (int i = 0; i < DEPTH; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[i*4+b]) merged_o[b*8 +: 8] = data_i[i*32+b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/dccm_store_buffer.sv
// Posted-store buffer between the core DCCM port and the data memory port.
// STB_FWD_EN: when defined, loads hitting buffered words are forwarded instead of stalled.
module dccm_store_buffer
  import rv32_x_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dccm_wr_en,
  input  logic [31:0]   dccm_wr_addr,
  input  logic [31:0]   dccm_wr_data,
  input  logic [1:0]    store_type,
  input  logic [1:0]    store_offset,
  output logic          st_ready,
  output logic          misalign_err,
  input  logic          dccm_rd_en,
  input  logic [31:0]   dccm_rd_addr,
  output logic          ld_ready,
  output logic [31:0]   dccm_rd_data,
  output logic          rd_valid,
  output logic          sb_empty,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_wr_addr,
  output logic [31:0]   mem_wr_data,
  output logic [3:0]    mem_wr_be,
  input  logic          mem_wr_ready,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [31:0]   mem_rd_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t       fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            misalign_q, rd_valid_q;

  logic [3:0]      st_be;
  logic            full, empty, push, pop, hit;
  sb_entry_t       new_entry, head;
  sb_entry_t       slot_ent [DEPTH];
  logic [DEPTH-1:0] slot_hit;

  assign st_be = be_gen(store_type, store_offset);
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = dccm_wr_en && st_ready && (st_be != 4'h0);
  assign pop   = !empty && mem_wr_ready;
  assign head  = fifo_q[rd_ptr_q];

  always_comb begin
    new_entry      = '0;
    new_entry.addr = 30'(dccm_wr_addr[AW+1:2]);
    new_entry.data = dccm_wr_data << {store_offset, 3'b000};
    new_entry.be   = st_be;
  end

  // Slot i is the i-th oldest pending store; the store being accepted this
  // cycle lands in slot count_q, so it is treated as older than the load.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_ent[i] = '0;
      slot_hit[i] = 1'b0;
      if (CW'(i) < count_q) begin
        slot_ent[i] = fifo_q[rd_ptr_q + PW'(i)];
        slot_hit[i] = (slot_ent[i].addr[AW-1:0] == dccm_rd_addr[AW+1:2]);
      end else if (push && (CW'(i) == count_q)) begin
        slot_ent[i] = new_entry;
        slot_hit[i] = (new_entry.addr[AW-1:0] == dccm_rd_addr[AW+1:2]);
      end
    end
  end

  assign hit = |slot_hit;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= new_entry;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      misalign_q <= dccm_wr_en && st_ready && (st_be == 4'h0);
      rd_valid_q <= mem_rd_en;
    end
  end

  assign st_ready     = !full;
  assign misalign_err = misalign_q;
  assign sb_empty     = empty;
  assign rd_valid     = rd_valid_q;

  assign mem_wr_en   = !empty;
  assign mem_wr_addr = empty ? '0 : head.addr[AW-1:0];
  assign mem_wr_data = empty ? '0 : head.data;
  assign mem_wr_be   = empty ? '0 : head.be;

  assign mem_rd_en   = dccm_rd_en && ld_ready;
  assign mem_rd_addr = mem_rd_en ? dccm_rd_addr[AW+1:2] : '0;

`ifdef STB_FWD_EN
  logic [DEPTH*32-1:0] snap_data_q;
  logic [DEPTH*4-1:0]  snap_be_q;
  logic [31:0]         merged;

  assign ld_ready = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_data_q <= '0;
      snap_be_q   <= '0;
    end else if (mem_rd_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        snap_data_q[i*32 +: 32] <= slot_ent[i].data;
        snap_be_q[i*4 +: 4]     <= slot_hit[i] ? slot_ent[i].be : 4'h0;
      end
    end
  end

  stb_byte_merge #(.DEPTH(DEPTH)) u_merge (
    .base_i   (mem_rd_data),
    .data_i   (snap_data_q),
    .be_i     (snap_be_q),
    .merged_o (merged)
  );

  assign dccm_rd_data = rd_valid_q ? merged : '0;
`else
  assign ld_ready     = !hit;
  assign dccm_rd_data = rd_valid_q ? mem_rd_data : '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{dccm_rd_addr[1:0], dccm_rd_addr[31:AW+2],
                         dccm_wr_addr[1:0], dccm_wr_addr[31:AW+2]};

endmodule

// File: tb/tb_dccm_store_buffer.sv
// Directed bench for dccm_store_buffer with a small byte-enabled sync memory model.
// Expectations follow STB_FWD_EN the same way the design does.
module tb_dccm_store_buffer;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dccm_wr_en;
  logic [31:0]   dccm_wr_addr, dccm_wr_data;
  logic [1:0]    store_type, store_offset;
  logic          st_ready, misalign_err;
  logic          dccm_rd_en;
  logic [31:0]   dccm_rd_addr;
  logic          ld_ready;
  logic [31:0]   dccm_rd_data;
  logic          rd_valid, sb_empty;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_wr_be;
  logic          mem_wr_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [31:0]   mem_rd_data = 32'h0;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wc0;
  logic [31:0] mem [0:1023];

  dccm_store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .dccm_wr_en(dccm_wr_en), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .store_type(store_type), .store_offset(store_offset),
    .st_ready(st_ready), .misalign_err(misalign_err),
    .dccm_rd_en(dccm_rd_en), .dccm_rd_addr(dccm_rd_addr),
    .ld_ready(ld_ready), .dccm_rd_data(dccm_rd_data), .rd_valid(rd_valid),
    .sb_empty(sb_empty),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_be(mem_wr_be), .mem_wr_ready(mem_wr_ready),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en && mem_wr_ready) begin
      for (int b = 0; b < 4; b++)
        if (mem_wr_be[b]) mem[mem_wr_addr[9:0]][b*8 +: 8] <= mem_wr_data[b*8 +: 8];
      wr_count = wr_count + 1;
    end
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] t, input logic [1:0] o);
    dccm_wr_en   = 1'b1;
    dccm_wr_addr = a;
    dccm_wr_data = d;
    store_type   = t;
    store_offset = o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n = 1'b0; dccm_wr_en = 1'b0; dccm_wr_addr = '0; dccm_wr_data = '0;
    store_type = 2'b00; store_offset = 2'b00; dccm_rd_en = 1'b0; dccm_rd_addr = '0;
    mem_wr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_st_ready", st_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    check("rst_sb_empty", sb_empty, 1);
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_misalign", misalign_err, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", dccm_rd_data, 0);

    // word store, immediate drain
    @(negedge clk); mem_wr_ready = 1'b1; store(32'h100, 32'hDEADBEEF, 2'b10, 2'd0);
    #1 check("t1_st_ready", st_ready, 1);
    @(negedge clk); dccm_wr_en = 1'b0;
    #1;
    check("t1_wr_en", mem_wr_en, 1);
    check("t1_wr_addr", 32'(mem_wr_addr), 32'h40);
    check("t1_wr_be", 32'(mem_wr_be), 32'hF);
    check("t1_wr_data", mem_wr_data, 32'hDEADBEEF);
    check("t1_not_empty", sb_empty, 0);
    @(negedge clk); #1;
    check("t1_empty", sb_empty, 1);
    check("t1_wr_idle", mem_wr_en, 0);
    check("t1_mem", mem[10'h40], 32'hDEADBEEF);

    // fill to full, fifth store held until space frees
    @(negedge clk); mem_wr_ready = 1'b0; wc0 = wr_count;
    store(32'h200, 32'd1, 2'b10, 2'd0); #1 check("t2_rdy0", st_ready, 1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); store(32'h200 + 32'(4*k), 32'(k+1), 2'b10, 2'd0);
      #1 check("t2_rdy", st_ready, 1);
    end
    @(negedge clk); store(32'h210, 32'd5, 2'b10, 2'd0); mem_wr_ready = 1'b1;
    #1;
    check("t2_full", st_ready, 0);
    check("t2_d0_addr", 32'(mem_wr_addr), 32'h80);
    check("t2_d0_data", mem_wr_data, 32'd1);
    @(negedge clk); #1;
    check("t2_space", st_ready, 1);
    check("t2_d1_addr", 32'(mem_wr_addr), 32'h81);
    check("t2_d1_data", mem_wr_data, 32'd2);
    @(negedge clk); dccm_wr_en = 1'b0;
    #1 check("t2_d2_addr", 32'(mem_wr_addr), 32'h82);
    @(negedge clk); #1 check("t2_d3_addr", 32'(mem_wr_addr), 32'h83);
    @(negedge clk); #1;
    check("t2_d4_addr", 32'(mem_wr_addr), 32'h84);
    check("t2_d4_data", mem_wr_data, 32'd5);
    @(negedge clk); #1;
    check("t2_empty", sb_empty, 1);
    check("t2_writes", 32'(wr_count - wc0), 32'd5);

    // byte lane placement, misaligned half and reserved type dropped
    @(negedge clk); mem_wr_ready = 1'b0; wc0 = wr_count;
    store(32'h300, 32'h000000AB, 2'b00, 2'd2);
    #1 check("t3_no_err", misalign_err, 0);
    @(negedge clk); store(32'h300, 32'h00001234, 2'b01, 2'd3);
    #1;
    check("t3_be", 32'(mem_wr_be), 32'h4);
    check("t3_data", mem_wr_data, 32'h00AB0000);
    check("t3_addr", 32'(mem_wr_addr), 32'hC0);
    @(negedge clk); store(32'h300, 32'h55, 2'b11, 2'd0);
    #1;
    check("t3_half_err", misalign_err, 1);
    check("t3_st_ready", st_ready, 1);
    @(negedge clk); dccm_wr_en = 1'b0;
    #1 check("t3_rsv_err", misalign_err, 1);
    @(negedge clk); mem_wr_ready = 1'b1;
    #1 check("t3_err_clr", misalign_err, 0);
    @(negedge clk); #1;
    check("t3_empty", sb_empty, 1);
    check("t3_writes", 32'(wr_count - wc0), 32'd1);
    check("t3_mem", mem[10'hC0], 32'h00AB0000);

    // load hitting two buffered byte stores
    @(negedge clk); mem_wr_ready = 1'b0; mem[10'h50] = 32'h11223344;
    store(32'h140, 32'hAA, 2'b00, 2'd0);
    @(negedge clk); store(32'h140, 32'hBB, 2'b00, 2'd0);
    @(negedge clk); dccm_wr_en = 1'b0; dccm_rd_en = 1'b1; dccm_rd_addr = 32'h140;
`ifdef STB_FWD_EN
    #1;
    check("t4_ld_ready", ld_ready, 1);
    check("t4_rd_en", mem_rd_en, 1);
    @(negedge clk); dccm_rd_en = 1'b0; mem_wr_ready = 1'b1;
    #1;
    check("t4_valid", rd_valid, 1);
    check("t4_data", dccm_rd_data, 32'h112233BB);
    repeat (2) @(negedge clk);
`else
    #1;
    check("t5_stall0", ld_ready, 0);
    check("t5_no_rd", mem_rd_en, 0);
    mem_wr_ready = 1'b1;
    @(negedge clk); #1 check("t5_stall1", ld_ready, 0);
    for (int n = 0; n < 8 && !ld_ready; n++) begin @(negedge clk); #1; end
    check("t5_ld_ready", ld_ready, 1);
    check("t5_rd_en", mem_rd_en, 1);
    check("t5_drained", sb_empty, 1);
    @(negedge clk); dccm_rd_en = 1'b0;
    #1;
    check("t5_valid", rd_valid, 1);
    check("t5_data", dccm_rd_data, 32'h112233BB);
`endif
    @(negedge clk); #1;
    check("t45_valid_clr", rd_valid, 0);
    check("t45_data_clr", dccm_rd_data, 0);
    check("t45_empty", sb_empty, 1);

    // non-hitting load returns memory unmodified
    mem[10'h60] = 32'hCAFEF00D;
    @(negedge clk); dccm_rd_en = 1'b1; dccm_rd_addr = 32'h180;
    #1 check("ld_miss_ready", ld_ready, 1);
    @(negedge clk); dccm_rd_en = 1'b0;
    #1;
    check("ld_miss_valid", rd_valid, 1);
    check("ld_miss_data", dccm_rd_data, 32'hCAFEF00D);

    // same-cycle store and load to the same word
    @(negedge clk); mem_wr_ready = 1'b0;
    store(32'h1C0, 32'h77, 2'b00, 2'd1); dccm_rd_en = 1'b1; dccm_rd_addr = 32'h1C0;
`ifdef STB_FWD_EN
    #1 check("same_ld_ready", ld_ready, 1);
    @(negedge clk); dccm_wr_en = 1'b0; dccm_rd_en = 1'b0;
    #1 check("same_fwd_data", dccm_rd_data, 32'h00007700);
`else
    #1 check("same_ld_ready", ld_ready, 0);
    @(negedge clk); dccm_wr_en = 1'b0; dccm_rd_en = 1'b0;
    #1 check("same_no_valid", rd_valid, 0);
`endif
    mem_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 check("same_empty", sb_empty, 1);

    // reset while draining
    @(negedge clk); mem_wr_ready = 1'b0; mem[10'h101] = 32'h0;
    store(32'h400, 32'd1, 2'b10, 2'd0);
    @(negedge clk); store(32'h404, 32'd2, 2'b10, 2'd0);
    @(negedge clk); dccm_wr_en = 1'b0; mem_wr_ready = 1'b1;
    #1 check("t6_drain0", mem_wr_en, 1);
    @(negedge clk); #1;
    check("t6_drain1", mem_wr_en, 1);
    wc0 = wr_count;
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_wr_en", mem_wr_en, 0);
    check("t6_rst_empty", sb_empty, 1);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("t6_no_write", 32'(wr_count - wc0), 32'd0);
    check("t6_wr_en", mem_wr_en, 0);
    check("t6_empty", sb_empty, 1);
    check("t6_st_ready", st_ready, 1);
    check("t6_mem", mem[10'h101], 32'h0);
    @(negedge clk); #1 check("t6_still_idle", mem_wr_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
